// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_ctrl
//  Purpose  : Memory-stage request controller sitting between the pipeline
//             EX/MEM register and mem_system (cache + four-bank memory).
//             Accepts one load/store at a time, rejects illegal requests
//             without touching memory, issues each legal access as a
//             single-cycle Rd/Wr pulse, waits for Done (bounded by TIMEOUT)
//             and returns a one-cycle response.
//  Ports    :
//    clk, rst                 clock, asynchronous active-high reset
//    req_valid/rd/wr          pipeline request strobe and operation
//    req_addr, req_wdata      byte address and store data
//    req_ready                high in IDLE only
//    stall                    pipeline must hold its MEM stage
//    resp_valid               one-cycle response strobe
//    resp_rdata/hit/err       response payload, held until the next response
//    mem_addr/datain/rd/wr    request side of mem_system
//    mem_dataout/done/stall/
//    mem_cachehit/err         completion side of mem_system
//  Revision : 1.0 - initial release
// ============================================================================
module mem_req_ctrl #(
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_hit,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_cachehit,
    input  logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value in the last permitted WAIT cycle: WAIT lasts at most
    // TIMEOUT cycles, with the counter running 0 .. TIMEOUT-1.
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_op_rd;
    logic             r_op_wr;
    logic             r_err_pend;   // mem_err seen during ISSUE
    logic [CNT_W-1:0] r_cnt;

    logic w_req_act;
    logic w_req_legal;
    logic w_unused;

    // Memory-side stall is informational only; completion is signalled by Done.
    assign w_unused    = mem_stall;

    assign w_req_act   = req_valid & (req_rd | req_wr);
    assign w_req_legal = (req_rd ^ req_wr) & ~req_addr[0];

    assign req_ready   = (r_state == S_IDLE);

    // rst gating keeps stall low while reset is held even if the pipeline
    // presents a request, so every output except req_ready reads 0 in reset.
    assign stall = ~rst & (((r_state == S_IDLE) & w_req_act) |
                           (r_state == S_ISSUE) |
                           (r_state == S_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op_rd    <= 1'b0;
            r_op_wr    <= 1'b0;
            r_err_pend <= 1'b0;
            r_cnt      <= '0;
            mem_addr   <= 16'h0000;
            mem_datain <= 16'h0000;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            // Strobes default low; they are raised for exactly one cycle below.
            resp_valid <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req_act) begin
                        if (w_req_legal) begin
                            r_op_rd    <= req_rd;
                            r_op_wr    <= req_wr;
                            mem_addr   <= req_addr;
                            mem_datain <= req_wdata;
                            // Raised now so the pulse lands in the ISSUE cycle.
                            mem_rd     <= req_rd;
                            mem_wr     <= req_wr;
                            r_state    <= S_ISSUE;
                        end else begin
                            // Illegal: answer with an error, memory untouched.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_rdata <= 16'h0000;
                            r_state    <= S_RESP;
                        end
                    end
                end

                S_ISSUE: begin
                    // A Done seen here belongs to an older access; only an
                    // error is kept for reporting.
                    r_cnt      <= '0;
                    r_err_pend <= mem_err;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (mem_err | r_err_pend) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_rdata <= 16'h0000;
                        r_state    <= S_RESP;
                    end else if (mem_done) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_hit   <= mem_cachehit;
                        resp_rdata <= r_op_rd ? mem_dataout : 16'h0000;
                        r_state    <= S_RESP;
                    end else if (r_cnt == c_TMO_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_rdata <= 16'h0000;
                        r_state    <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_err_pend <= 1'b0;
                    r_op_rd    <= 1'b0;
                    r_op_wr    <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
